fpu_operand_loader: RTL and testbench
=====================================

Name: fpu_operand_loader

Overview:
Input-side counterpart to the FPU's display/output path. It reads byte-serial frames from the input switches (ui_in), clocked in by a manual strobe on a bidirectional pin. It assembles each frame into an opcode and two 16-bit half-precision operands, then presents them to the FPU core with a valid/ready handshake. It sits between the tt_um top-level pins and the FPU datapath.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the strobe synchronizer (minimum 2)
HDR_TAG, 5'b10100, required value of header byte bits [7:3]
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (0.1 s at 10 MHz); used only with the optional feature

Ports:
clk  input  1  system clock (10 MHz)
reset  input  1  synchronous, active-high reset
data_in  input  8  byte from ui_in; must be stable from strobe rise until SYNC_STAGES+2 cycles later
strobe_in  input  1  asynchronous byte strobe from uio_in[0]; a rising edge loads one byte
opcode  output  3  FPU opcode from header bits [2:0]
op_a  output  16  operand A as {byte1, byte2}
op_b  output  16  operand B as {byte3, byte4}
op_valid  output  1  operands and opcode are valid
op_ready  input  1  FPU core accepts the operands
busy  output  1  high when a frame is in progress (state is not IDLE)
byte_idx  output  3  number of bytes received in the current frame (0..5)
hdr_err  output  1  one-cycle pulse when a header byte is rejected
overrun  output  1  sticky flag: a strobe was dropped while in HOLD
timeout  output  1  one-cycle pulse when a frame is aborted; always 0 without the optional feature

Behaviour:
- Reset: all of the following go to 0 — opcode, op_a, op_b, op_valid, busy, byte_idx, hdr_err, overrun, timeout. The synchronizer chain and the edge-detect register also go to 0. State goes to IDLE. Reset mid-frame discards any partial frame.
- Strobe detection: strobe_in passes through SYNC_STAGES flops. An edge is declared in the cycle where the last sync stage is 1 and its delayed copy is 0. data_in is captured in that same cycle. Each rising edge yields exactly one byte; holding the strobe high produces no repeat.
- FSM states: IDLE, A_HI, A_LO, B_HI, B_LO, HOLD.
- IDLE + edge:
  - If data_in[7:3] == HDR_TAG: latch opcode = data_in[2:0], clear overrun, go to A_HI, byte_idx = 1.
  - Otherwise: pulse hdr_err for one cycle and stay in IDLE.
- A_HI, A_LO, B_HI, B_LO + edge: latch op_a[15:8], op_a[7:0], op_b[15:8], op_b[7:0] respectively. Advance one state and increment byte_idx.
- B_LO + edge: go to HOLD, byte_idx = 5, and op_valid = 1 starting the next cycle. Latency from the B_LO edge to op_valid is 1 cycle.
- HOLD:
  - op_valid, opcode, op_a and op_b are held stable until op_valid && op_ready.
  - On that handshake cycle: op_valid goes to 0 on the next cycle, byte_idx goes to 0, state goes to IDLE.
  - Any edge in HOLD, including one in the handshake cycle itself, is dropped and sets overrun.
- op_ready outside HOLD is ignored.
- busy equals (state != IDLE).
- Operand registers keep their last value after a handshake; they are not cleared.

Optional Feature:
Macro FPU_FRAME_TIMEOUT_EN.
- When defined: a counter clears on each accepted edge and counts while in A_HI..B_LO. When it reaches TIMEOUT_CYCLES-1 without an edge, the FSM returns to IDLE, byte_idx goes to 0, and timeout pulses for one cycle. If an edge occurs in the same cycle as expiry, the edge wins and the byte is accepted. There is no timeout in IDLE or HOLD.
- When not defined: no counter is built, timeout is tied to 0, and a partial frame waits indefinitely.

Decomposition:
- Package fpu_io_pkg contains:
  - loader state enum (IDLE..HOLD)
  - HDR_TAG default constant
  - FRAME_BYTES = 5
  - 3-bit opcode enum shared with the FPU core: ADD=0, SUB=1, MUL=2, DIV=3, CMP=4
- One sub-module, strobe_sync_edge: a parameterized SYNC_STAGES synchronizer with a rising-edge pulse output. It will be reused for future button inputs.

Test Plan:
- Send frame A1,3C,00,40,00 with op_ready=0 -> opcode=1, op_a=16'h3C00, op_b=16'h4000. op_valid rises 1 cycle after the 5th detected edge and stays stable for 20 cycles. Then op_ready=1 for 1 cycle -> op_valid=0 and busy=0 on the next cycle.
- Send bad header 0x55 -> hdr_err pulses exactly one cycle, busy stays 0. A following valid frame A2,.. is accepted normally.
- Strobe held high for 100 cycles with one rising edge -> exactly one byte captured and byte_idx increments by exactly 1. Verify edge detection occurs SYNC_STAGES+1 cycles after the rise.
- While in HOLD, apply 2 extra strobes, including one in the handshake cycle -> overrun=1 and outputs are unchanged. A next valid header clears overrun.
- Assert reset after 3 bytes -> all outputs are 0 and state is IDLE next cycle. A new full frame A4,12,34,56,78 -> op_a=16'h1234, op_b=16'h5678.
- With FPU_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 2 bytes, then idle 50 cycles -> timeout pulses once, byte_idx=0, busy=0. An edge landing exactly on the expiry cycle is accepted.

Source files
------------

// File: rtl/fpu_io_pkg.sv
// Shared types for the FPU I/O path: loader FSM states, frame constants, FPU opcodes.
// Latency: n/a (types only); backpressure: n/a.
package fpu_io_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_HI = 3'd1,
        A_LO = 3'd2,
        B_HI = 3'd3,
        B_LO = 3'd4,
        HOLD = 3'd5
    } loader_state_t;

    localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;
    localparam int         FRAME_BYTES     = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_CMP = 3'd4
    } fpu_op_t;

endpackage

// File: rtl/strobe_sync_edge.sv
// Multi-flop synchronizer for an async level input with a one-cycle rising-edge pulse.
// Latency: rise is high SYNC_STAGES cycles after the input rises; backpressure: none.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/fpu_operand_loader.sv
// Assembles strobed 5-byte frames (header, A hi/lo, B hi/lo) into FPU opcode + operands.
// Latency: op_valid 1 cycle after the last byte edge; backpressure: held in HOLD until
// op_ready, strobes there are dropped and flagged. FPU_FRAME_TIMEOUT_EN adds a frame timeout.
module fpu_operand_loader
    import fpu_io_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [4:0] HDR_TAG        = HDR_TAG_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        strobe_in,
    output logic [2:0]  opcode,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        busy,
    output logic [2:0]  byte_idx,
    output logic        hdr_err,
    output logic        overrun,
    output logic        timeout
);

    loader_state_t state;
    logic          byte_edge;
    logic          expire;

    strobe_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (strobe_in),
        .rise     (byte_edge)
    );

`ifdef FPU_FRAME_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             collecting;
    logic [TMO_W-1:0] tmo_cnt;

    assign collecting = (state == A_HI) || (state == A_LO) ||
                        (state == B_HI) || (state == B_LO);
    // An edge on the expiry cycle suppresses expiry, so the byte is kept.
    assign expire     = collecting && !byte_edge &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !collecting || byte_edge || expire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Partial frames wait forever; the parameter stays referenced so both builds share one interface.
    assign expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opcode   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            byte_idx <= '0;
            hdr_err  <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            hdr_err <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_edge) begin
                        if (data_in[7:3] == HDR_TAG) begin
                            opcode   <= data_in[2:0];
                            overrun  <= 1'b0;
                            state    <= A_HI;
                            byte_idx <= 3'd1;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                A_HI, A_LO, B_HI, B_LO: begin
                    if (byte_edge) begin
                        byte_idx <= byte_idx + 3'd1;
                        case (state)
                            A_HI: begin
                                op_a[15:8] <= data_in;
                                state      <= A_LO;
                            end
                            A_LO: begin
                                op_a[7:0] <= data_in;
                                state     <= B_HI;
                            end
                            B_HI: begin
                                op_b[15:8] <= data_in;
                                state      <= B_LO;
                            end
                            default: begin
                                op_b[7:0] <= data_in;
                                state     <= HOLD;
                                byte_idx  <= 3'(FRAME_BYTES);
                                op_valid  <= 1'b1;
                            end
                        endcase
                    end else if (expire) begin
                        state    <= IDLE;
                        byte_idx <= '0;
                        timeout  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (byte_edge) begin
                        overrun <= 1'b1;
                    end
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        byte_idx <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_valid <= 1'b0;
                    byte_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader with a frame scoreboard checked at each handshake.
module tb_fpu_operand_loader;
    import fpu_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = '0;
    logic        strobe_in = 1'b0;
    logic [2:0]  opcode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        busy;
    logic [2:0]  byte_idx;
    logic        hdr_err;
    logic        overrun;
    logic        timeout;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } frame_t;

    frame_t sb[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     hdr_pulses = 0;
    int     tmo_pulses = 0;
    bit     busy_seen = 1'b0;
    logic [2:0] pre_idx, post_idx;
    logic       pre_vld, post_vld;

    fpu_operand_loader #(
        .SYNC_STAGES    (2),
        .HDR_TAG        (5'b10100),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .strobe_in (strobe_in),
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .busy      (busy),
        .byte_idx  (byte_idx),
        .hdr_err   (hdr_err),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (hdr_err) hdr_pulses++;
        if (timeout) tmo_pulses++;
        if (busy)    busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the strobe, sample just before and just after the byte is taken, then release.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in   = b;
        strobe_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pre_idx = byte_idx;
        pre_vld = op_valid;
        @(posedge clk);
        #1;
        post_idx = byte_idx;
        post_vld = op_valid;
        @(posedge clk);
        @(negedge clk);
        strobe_in = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [15:0] a, input logic [15:0] b);
        logic [7:0] fb[5];
        fb[0] = hdr;
        fb[1] = a[15:8];
        fb[2] = a[7:0];
        fb[3] = b[15:8];
        fb[4] = b[7:0];
        sb.push_back({hdr[2:0], a, b});
        for (int i = 0; i < 5; i++) begin
            send_byte(fb[i]);
            chk("idx_before_edge", 64'(pre_idx), 64'(i));
            chk("idx_after_edge", 64'(post_idx), 64'(i + 1));
        end
        chk("valid_before_last", 64'(pre_vld), 64'd0);
        chk("valid_after_last", 64'(post_vld), 64'd1);
    endtask

    task automatic accept();
        frame_t exp;
        @(negedge clk);
        op_ready = 1'b1;
        chk("valid_at_handshake", 64'(op_valid), 64'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            chk("frame", 64'({opcode, op_a, op_b}), 64'(exp));
        end
        @(negedge clk);
        op_ready = 1'b0;
        chk("valid_after_hs", 64'(op_valid), 64'd0);
        chk("busy_after_hs", 64'(busy), 64'd0);
        chk("idx_after_hs", 64'(byte_idx), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({opcode, op_a, op_b, op_valid, busy, byte_idx, hdr_err, overrun, timeout}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic frame, held 20 cycles before acceptance
        send_frame(8'hA1, 16'h3C00, 16'h4000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_stable", 64'({op_valid, opcode, op_a, op_b}), 64'({1'b1, sb[0]}));
        end
        chk("opcode_sub", 64'(opcode), 64'(OP_SUB));
        accept();

        // Bad header, then a good frame
        hdr_pulses = 0;
        busy_seen  = 1'b0;
        send_byte(8'h55);
        chk("hdr_err_pulses", 64'(hdr_pulses), 64'd1);
        chk("busy_on_bad_hdr", 64'(busy_seen), 64'd0);
        send_frame(8'hA2, 16'h1122, 16'h3344);
        accept();

        // Strobe held high: one byte only, taken SYNC_STAGES+1 cycles after the rise
        @(negedge clk);
        data_in   = 8'hA3;
        strobe_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held_idx_early", 64'(byte_idx), 64'd0);
        @(posedge clk);
        #1;
        chk("held_idx_taken", 64'(byte_idx), 64'd1);
        repeat (97) @(posedge clk);
        #1;
        chk("held_idx_no_repeat", 64'(byte_idx), 64'd1);
        @(negedge clk);
        strobe_in = 1'b0;
        repeat (3) @(posedge clk);
        sb.push_back({3'd3, 16'h5A5A, 16'hC33C});
        send_byte(8'h5A);
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_byte(8'h3C);
        chk("held_frame_idx", 64'(post_idx), 64'd5);
        accept();

        // Strobes while holding: dropped and flagged
        send_frame(8'hA0, 16'hABCD, 16'hEF01);
        send_byte(8'hFF);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("hold_unchanged", 64'({op_valid, byte_idx, opcode, op_a, op_b}), 64'({1'b1, 3'd5, sb[0]}));
        hdr_pulses = 0;
        @(negedge clk);
        data_in   = 8'hA5;
        strobe_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op_ready = 1'b1;
        chk("frame_at_hs_edge", 64'({opcode, op_a, op_b}), 64'(sb.pop_front()));
        @(posedge clk);
        @(negedge clk);
        op_ready  = 1'b0;
        strobe_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hs_edge_dropped", 64'({busy, op_valid, byte_idx, overrun}), 64'({1'b0, 1'b0, 3'd0, 1'b1}));
        chk("hs_edge_no_hdr_err", 64'(hdr_pulses), 64'd0);
        chk("operands_retained", 64'({op_a, op_b}), 64'h0000_0000_ABCD_EF01);
        send_byte(8'hA1);
        chk("overrun_cleared", 64'(overrun), 64'd0);

        // Reset mid-frame after three bytes
        send_byte(8'h12);
        send_byte(8'h34);
        chk("idx_before_reset", 64'(byte_idx), 64'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_reset", 64'({opcode, op_a, op_b, op_valid, busy, byte_idx, hdr_err, overrun, timeout}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(8'hA4, 16'h1234, 16'h5678);
        chk("opcode_cmp", 64'(opcode), 64'(OP_CMP));
        accept();

`ifdef FPU_FRAME_TIMEOUT_EN
        // Header accepted at P; second byte lands exactly on the expiry cycle P+50
        tmo_pulses = 0;
        send_byte(8'hA1);
        repeat (43) @(posedge clk);
        send_byte(8'h11);
        chk("expiry_edge_pre", 64'(pre_idx), 64'd1);
        chk("expiry_edge_wins", 64'(post_idx), 64'd2);
        chk("no_timeout_on_edge", 64'(tmo_pulses), 64'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("timeout_pulses", 64'(tmo_pulses), 64'd1);
        chk("timeout_state", 64'({busy, byte_idx}), 64'd0);
`else
        chk("timeout_never", 64'(tmo_pulses), 64'd0);
`endif

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
